// File: rtl/sram_byte_loader.sv
// sram_byte_loader: packs an 8-bit Avalon-ST byte stream little-endian into 32-bit SRAM words.
// Optional read-back checksum verify is built in when SRAM_LOADER_VERIFY_EN is defined.
module sram_byte_loader #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned LEN_W  = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  len_bytes,
    input  logic [7:0]        st_data,
    input  logic              st_valid,
    output logic              st_ready,
    output logic [ADDR_W-1:0] sram_address,
    output logic              sram_chipselect,
    output logic              sram_write,
    output logic [3:0]        sram_byteenable,
    output logic [31:0]       sram_writedata,
    input  logic [31:0]       sram_readdata,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int unsigned LANES = 4;

`ifdef SRAM_LOADER_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, WRITE, VR_ADDR, VR_DATA, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;
`endif

    state_t            state, state_nx;
    logic [ADDR_W-1:0] addr_nx;
    logic [LEN_W-1:0]  rem_q, rem_nx;
    logic [1:0]        lane_q, lane_nx;
    logic [31:0]       wdata_nx;
    logic [3:0]        be_nx;
    logic              beat;

`ifdef SRAM_LOADER_VERIFY_EN
    logic [ADDR_W-1:0] base_q;
    logic [LEN_W-1:0]  len_q;
    logic [15:0]       sum16_q, sum16_nx;
    logic [15:0]       rb_sum_q, rb_sum_nx;
    logic [15:0]       word_sum;
    logic [3:0]        rd_mask;
    logic              err_nx;
`else
    logic              unused_readdata;
    assign unused_readdata = ^sram_readdata;
    assign err             = 1'b0;
`endif

    // st_ready is registered and high exactly while in LOAD
    assign beat = st_valid & st_ready;

    // Next-state and datapath update
    always_comb begin
        state_nx = state;
        addr_nx  = sram_address;
        rem_nx   = rem_q;
        lane_nx  = lane_q;
        wdata_nx = sram_writedata;
        be_nx    = sram_byteenable;
`ifdef SRAM_LOADER_VERIFY_EN
        sum16_nx  = sum16_q;
        rb_sum_nx = rb_sum_q;
        err_nx    = err;
        rd_mask   = '0;
        word_sum  = '0;
`endif
        case (state)
            IDLE: begin
                if (start) begin
                    addr_nx  = base_addr;
                    rem_nx   = len_bytes;
                    lane_nx  = '0;
                    wdata_nx = '0;
                    be_nx    = '0;
`ifdef SRAM_LOADER_VERIFY_EN
                    sum16_nx  = '0;
                    rb_sum_nx = '0;
                    err_nx    = 1'b0;
`endif
                    state_nx = (len_bytes == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                if (beat) begin
                    wdata_nx[{lane_q, 3'b000} +: 8] = st_data;
                    be_nx[lane_q] = 1'b1;
                    lane_nx       = lane_q + 2'd1;
                    rem_nx        = rem_q - LEN_W'(1);
`ifdef SRAM_LOADER_VERIFY_EN
                    sum16_nx = sum16_q + 16'(st_data);
`endif
                    if (lane_q == 2'd3 || rem_q == LEN_W'(1)) begin
                        state_nx = WRITE;
                    end
                end
            end
            WRITE: begin
                addr_nx  = sram_address + ADDR_W'(1);
                lane_nx  = '0;
                wdata_nx = '0;
                be_nx    = '0;
                if (rem_q == '0) begin
`ifdef SRAM_LOADER_VERIFY_EN
                    state_nx = VR_ADDR;
                    addr_nx  = base_q;
                    rem_nx   = len_q;
`else
                    state_nx = DONE;
`endif
                end else begin
                    state_nx = LOAD;
                end
            end
`ifdef SRAM_LOADER_VERIFY_EN
            VR_ADDR: begin
                state_nx = VR_DATA;
            end
            VR_DATA: begin
                // last word only sums the lanes that were actually written
                rd_mask = (rem_q >= LEN_W'(LANES)) ? 4'hF
                                                   : 4'((5'd1 << rem_q[1:0]) - 5'd1);
                for (int unsigned k = 0; k < LANES; k++) begin
                    if (rd_mask[k]) begin
                        word_sum = word_sum + 16'(sram_readdata[8*k +: 8]);
                    end
                end
                rb_sum_nx = rb_sum_q + word_sum;
                addr_nx   = sram_address + ADDR_W'(1);
                if (rem_q <= LEN_W'(LANES)) begin
                    rem_nx   = '0;
                    err_nx   = (rb_sum_nx != sum16_q);
                    state_nx = DONE;
                end else begin
                    rem_nx   = rem_q - LEN_W'(LANES);
                    state_nx = VR_ADDR;
                end
            end
`endif
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // State register and registered outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state           <= IDLE;
            st_ready        <= 1'b0;
            busy            <= 1'b0;
            done            <= 1'b0;
            sram_chipselect <= 1'b0;
            sram_write      <= 1'b0;
            sram_address    <= '0;
            sram_byteenable <= '0;
            sram_writedata  <= '0;
            rem_q           <= '0;
            lane_q          <= '0;
`ifdef SRAM_LOADER_VERIFY_EN
            base_q   <= '0;
            len_q    <= '0;
            sum16_q  <= '0;
            rb_sum_q <= '0;
            err      <= 1'b0;
`endif
        end else begin
            state           <= state_nx;
            st_ready        <= (state_nx == LOAD);
            busy            <= (state_nx != IDLE) && (state_nx != DONE);
            done            <= (state_nx == DONE);
            sram_write      <= (state_nx == WRITE);
            sram_address    <= addr_nx;
            sram_byteenable <= be_nx;
            sram_writedata  <= wdata_nx;
            rem_q           <= rem_nx;
            lane_q          <= lane_nx;
`ifdef SRAM_LOADER_VERIFY_EN
            sram_chipselect <= (state_nx == WRITE) || (state_nx == VR_ADDR);
            if (state == IDLE && start) begin
                base_q <= base_addr;
                len_q  <= len_bytes;
            end
            sum16_q  <= sum16_nx;
            rb_sum_q <= rb_sum_nx;
            err      <= err_nx;
`else
            sram_chipselect <= (state_nx == WRITE);
`endif
        end
    end

endmodule
